// File: rtl/mmio_pkg.sv
// mmio_pkg: servo hub address map and default timing constants
package mmio_pkg;
   localparam logic [11:0] ADDR_LED        = 12'h006;
   localparam logic [11:0] ADDR_BTN_STATE  = 12'h007;
   localparam logic [11:0] ADDR_BTN_EDGE   = 12'h008;
   localparam logic [11:0] ADDR_SERVO_BASE = 12'h00B;
   localparam int unsigned DEF_PERIOD_CYCLES   = 1_000_000;
   localparam int unsigned DEF_MIN_PULSE       = 50_000;
   localparam int unsigned DEF_STEP            = 50;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadowed duty register and pulse compare against the shared period counter
module pwm_channel
   import mmio_pkg::*;
#(
   parameter int unsigned DUTY_W    = 10,
   parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
   parameter int unsigned STEP      = DEF_STEP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       cnt,
   input  logic              start,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm
);
   logic [DUTY_W-1:0] shadow, cur;
   logic [31:0]       width;
   // at period start the compare already uses the duty being loaded, so no pulse mixes two widths
   assign cur   = start ? duty : shadow;
   assign width = 32'(MIN_PULSE) + 32'(cur) * 32'(STEP);
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         shadow <= '0;
         pwm    <= 1'b0;
      end else begin
         if (start) shadow <= duty;
         pwm <= cnt < width;
      end
endmodule

// File: rtl/mmio_servo_hub.sv
// mmio_servo_hub: MMIO hub with servo PWM channels, debounced buttons and an LED register
module mmio_servo_hub
   import mmio_pkg::*;
#(
   parameter int unsigned NUM_SERVO       = 4,
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned DUTY_W          = 10,
   parameter int unsigned PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
   parameter int unsigned MIN_PULSE       = DEF_MIN_PULSE,
   parameter int unsigned STEP            = DEF_STEP,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [11:0]          addr,
   input  logic                 wen,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 hit,
   input  logic [NUM_BTN-1:0]   btn_in,
   output logic [15:0]          led,
   output logic [NUM_SERVO-1:0] servo_pwm
);
   logic [DUTY_W-1:0]  duty [NUM_SERVO];
   logic [NUM_BTN-1:0] btn_lvl, btn_rise, btn_edge, edge_clr;
   logic [31:0]        pwm_cnt, rd_mux;
   logic               rd_hit, period_start, unused_wdata;
   assign unused_wdata = ^wdata;
   assign period_start = pwm_cnt == 32'd0;
   always_ff @(posedge clock or negedge reset)
      if (!reset) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt == PERIOD_CYCLES - 1 ? '0 : pwm_cnt + 32'd1;
   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      logic [1:0]  sync;
      logic [31:0] cnt;
      logic        lvl, flip;
      assign flip = sync[1] != lvl && cnt == DEBOUNCE_CYCLES - 1;
      always_ff @(posedge clock or negedge reset)
         if (!reset) begin
            sync <= '0;
            cnt  <= '0;
            lvl  <= 1'b0;
         end else begin
            sync <= {sync[0], btn_in[b]};
            cnt  <= sync[1] == lvl || flip ? '0 : cnt + 32'd1;
            lvl  <= lvl ^ flip;
         end
      assign btn_lvl[b]  = lvl;
      assign btn_rise[b] = flip & ~lvl;
   end
   // a rising edge on the same cycle as its clear wins, so no press is ever lost
   assign edge_clr = wen && addr == ADDR_BTN_EDGE ? wdata[NUM_BTN-1:0] : '0;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         led      <= '0;
         btn_edge <= '0;
         rdata    <= '0;
         hit      <= 1'b0;
         for (int i = 0; i < NUM_SERVO; i++) duty[i] <= '0;
      end else begin
         if (wen && addr == ADDR_LED) led <= wdata[15:0];
         for (int i = 0; i < NUM_SERVO; i++)
            if (wen && addr == ADDR_SERVO_BASE + 12'(i)) duty[i] <= wdata[DUTY_W-1:0];
         btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
         rdata    <= rd_mux;
         hit      <= rd_hit;
      end
   always_comb begin
      rd_mux = '0;
      rd_hit = 1'b1;
      if (addr == ADDR_LED) rd_mux = {16'h0, led};
      else if (addr == ADDR_BTN_STATE) rd_mux = 32'(btn_lvl);
      else if (addr == ADDR_BTN_EDGE) rd_mux = 32'(btn_edge);
      else rd_hit = 1'b0;
      for (int i = 0; i < NUM_SERVO; i++)
         if (addr == ADDR_SERVO_BASE + 12'(i)) begin
            rd_mux = 32'(duty[i]);
            rd_hit = 1'b1;
         end
   end
   for (genvar s = 0; s < NUM_SERVO; s++) begin : g_servo
      pwm_channel #(
         .DUTY_W(DUTY_W),
         .MIN_PULSE(MIN_PULSE),
         .STEP(STEP)
      ) u_ch (
         .clock(clock),
         .reset(reset),
         .cnt(pwm_cnt),
         .start(period_start),
         .duty(duty[s]),
         .pwm(servo_pwm[s])
      );
   end
endmodule

// File: tb/tb_mmio_servo_hub.sv
// tb_mmio_servo_hub: directed and random checks of the servo hub against a register-level model
module tb_mmio_servo_hub;
   logic        clock, reset, wen, hit;
   logic [11:0] addr;
   logic [31:0] wdata, rdata;
   logic [3:0]  btn_in, servo_pwm;
   logic [15:0] led;
   int vectors = 0, miscompares = 0;
   logic [15:0] mled;
   logic [9:0]  mduty [4];
   logic [3:0]  mlvl, medge;
   int          run [4];
   logic [3:0]  hist [$];
   int          hcnt [4];
   int          dsel [4];
   logic [11:0] alist [10] = '{12'h006, 12'h007, 12'h008, 12'h00B, 12'h00C,
                               12'h00D, 12'h00E, 12'h00A, 12'h00F, 12'h010};

   mmio_servo_hub #(
      .NUM_SERVO(4), .NUM_BTN(4), .DUTY_W(10), .PERIOD_CYCLES(1000),
      .MIN_PULSE(100), .STEP(1), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock(clock), .reset(reset), .addr(addr), .wen(wen), .wdata(wdata),
      .rdata(rdata), .hit(hit), .btn_in(btn_in), .led(led), .servo_pwm(servo_pwm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mled = '0; mlvl = '0; medge = '0;
      for (int i = 0; i < 4; i++) begin mduty[i] = '0; run[i] = 0; end
      hist.delete();
   endtask

   // One clock: predict the read of the current address from pre-edge state, apply the
   // write and the button model, then compare after the edge.
   task automatic tick();
      logic [31:0] er;
      logic        eh;
      logic [3:0]  seen, rise, clr;
      int          idx;
      er = '0; eh = 1'b0; clr = '0; rise = '0;
      idx = int'(addr) - 11;
      if (addr == 12'h006) begin er = {16'h0, mled}; eh = 1'b1; end
      else if (addr == 12'h007) begin er = {28'h0, mlvl}; eh = 1'b1; end
      else if (addr == 12'h008) begin er = {28'h0, medge}; eh = 1'b1; end
      else if (idx >= 0 && idx < 4) begin er = {22'h0, mduty[idx]}; eh = 1'b1; end
      if (wen) begin
         if (addr == 12'h006) mled = wdata[15:0];
         if (addr == 12'h008) clr = wdata[3:0];
         if (idx >= 0 && idx < 4) mduty[idx] = wdata[9:0];
      end
      // the debouncer sees the pin two clocks late; four differing samples in a row flip it
      hist.push_back(btn_in);
      if (hist.size() > 3) void'(hist.pop_front());
      seen = hist.size() >= 3 ? hist[hist.size()-3] : 4'h0;
      for (int b = 0; b < 4; b++) begin
         run[b] = seen[b] != mlvl[b] ? run[b] + 1 : 0;
         if (run[b] == 4) begin
            mlvl[b] = ~mlvl[b];
            run[b]  = 0;
            rise[b] = mlvl[b];
         end
      end
      medge = (medge & ~clr) | rise;
      @(negedge clock);
      chk("rdata", rdata, er);
      chk("hit", 32'(hit), 32'(eh));
      chk("led", 32'(led), 32'(mled));
   endtask

   task automatic measure_period();
      int n = 0;
      wen = 1'b0;
      while (servo_pwm[0] && n < 1100) begin tick(); n++; end
      while (!servo_pwm[0] && n < 2200) begin tick(); n++; end
      chk("pwm_align", 32'(servo_pwm[0]), 32'd1);
      for (int c = 0; c < 4; c++) hcnt[c] = 0;
      repeat (1000) begin
         for (int c = 0; c < 4; c++) hcnt[c] += int'(servo_pwm[c]);
         tick();
      end
   endtask

   initial begin
      reset = 1'b0; btn_in = '0; addr = '0; wen = 1'b0; wdata = '0;
      repeat (3) @(negedge clock);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_pwm", 32'(servo_pwm), 32'd0);
      model_reset();
      reset = 1'b1;
      // two whole periods from release; duty 200 written mid-pulse of the first
      for (int c = 0; c < 4; c++) hcnt[c] = 0;
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            for (int c = 0; c < 4; c++) chk($sformatf("first_pulse%0d", c), 32'(hcnt[c]), 32'd100);
            for (int c = 0; c < 4; c++) hcnt[c] = 0;
         end
         addr = 12'h00B; wen = i == 50; wdata = 32'd200;
         tick();
         for (int c = 0; c < 4; c++) hcnt[c] += int'(servo_pwm[c]);
      end
      wen = 1'b0;
      chk("duty_pulse0", 32'(hcnt[0]), 32'd300);
      for (int c = 1; c < 4; c++) chk($sformatf("duty_pulse%0d", c), 32'(hcnt[c]), 32'd100);
      tick();
      chk("duty_rd", rdata, 32'd200);
      chk("duty_hit", 32'(hit), 32'd1);
      // debounce: 3-cycle glitches never pass, then a stable high flips after 2+4 edges
      addr = 12'h007;
      repeat (3) begin
         btn_in[0] = 1'b1; repeat (3) tick();
         btn_in[0] = 1'b0; repeat (3) tick();
      end
      chk("glitch_state", rdata, 32'd0);
      btn_in[0] = 1'b1;
      repeat (6) tick();
      chk("state_pre", rdata, 32'd0);
      tick();
      chk("state_set", rdata, 32'd1);
      addr = 12'h008;
      tick();
      chk("edge_set", rdata, 32'd1);
      btn_in[0] = 1'b0;
      repeat (8) tick();
      wen = 1'b1; wdata = 32'h1; tick(); wen = 1'b0; tick();
      chk("edge_clr", rdata, 32'd0);
      btn_in[0] = 1'b1;
      repeat (5) tick();
      wen = 1'b1; wdata = 32'h1; tick(); wen = 1'b0; tick();
      chk("w1c_same_edge", rdata, 32'd1);
      wen = 1'b1; wdata = 32'h2; tick(); wen = 1'b0; tick();
      chk("w1c_other_bit", rdata, 32'd1);
      wen = 1'b1; wdata = 32'h1; tick(); wen = 1'b0; tick();
      chk("w1c_clear", rdata, 32'd0);
      // LED and read-during-write
      addr = 12'h006; wen = 1'b1; wdata = 32'h0000_A5A5; tick(); wen = 1'b0;
      chk("led_a5a5", 32'(led), 32'hA5A5);
      wen = 1'b1; wdata = 32'h1234_5A5A; tick(); wen = 1'b0;
      chk("rw_old", rdata, 32'hA5A5);
      chk("led_new", 32'(led), 32'h5A5A);
      tick();
      chk("rd_new", rdata, 32'h5A5A);
      // unmapped
      addr = 12'h00F; tick();
      chk("unmap_hit", 32'(hit), 32'd0);
      chk("unmap_rdata", rdata, 32'd0);
      addr = 12'h010; wen = 1'b1; wdata = 32'hFFFF_FFFF; tick();
      addr = 12'h00A; tick(); wen = 1'b0;
      chk("unmap_led", 32'(led), 32'h5A5A);
      addr = 12'h00B; tick();
      chk("unmap_duty", rdata, 32'd200);
      // random bus traffic and button activity against the model
      repeat (600) begin
         addr  = $urandom_range(0, 7) == 0 ? 12'($urandom) : alist[$urandom_range(0, 9)];
         wen   = $urandom_range(0, 2) == 0;
         wdata = $urandom;
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) btn_in[b] = ~btn_in[b];
         tick();
      end
      // distinct duties on every channel, upper wdata bits random
      for (int c = 0; c < 4; c++) begin
         dsel[c] = $urandom_range(0, 199) + 200 * c;
         addr = 12'h00B + 12'(c); wen = 1'b1;
         wdata = ($urandom & 32'hFFFF_FC00) | 32'(dsel[c]);
         tick();
      end
      wen = 1'b0;
      measure_period();
      for (int c = 0; c < 4; c++) chk($sformatf("multi_pulse%0d", c), 32'(hcnt[c]), 32'(100 + dsel[c]));
      for (int c = 0; c < 4; c++) begin
         addr = 12'h00B + 12'(c); tick();
         chk($sformatf("multi_rd%0d", c), rdata, 32'(dsel[c]));
      end
      // asynchronous reset in mid-period, between clock edges
      #2 reset = 1'b0;
      #1;
      chk("async_led", 32'(led), 32'd0);
      chk("async_pwm", 32'(servo_pwm), 32'd0);
      chk("async_rdata", rdata, 32'd0);
      chk("async_hit", 32'(hit), 32'd0);
      btn_in = '0; addr = 12'h006; wen = 1'b0;
      repeat (2) @(negedge clock);
      model_reset();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) hcnt[c] = 0;
      repeat (1000) begin
         tick();
         for (int c = 0; c < 4; c++) hcnt[c] += int'(servo_pwm[c]);
      end
      for (int c = 0; c < 4; c++) chk($sformatf("rerst_pulse%0d", c), 32'(hcnt[c]), 32'd100);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mmio_servo_hub.md
# mmio_servo_hub

Memory-mapped peripheral hub on the processor's data-memory bus: NUM_SERVO servo PWM channels with glitch-free duty updates, NUM_BTN debounced buttons with sticky rising-edge flags, and a 16-bit LED register. It sits beside RAM in the top-level wrapper; the wrapper drives the processor data address, write enable and write data into it, and muxes `rdata` over RAM output when `hit` is high. Read latency matches synchronous RAM.

## Interface
- NUM_SERVO, 4, servo channels (1–8)
- NUM_BTN, 4, button inputs (1–16)
- DUTY_W, 10, duty register width
- PERIOD_CYCLES, 1_000_000, PWM period in clocks (20 ms at 50 MHz)
- MIN_PULSE, 50_000, pulse width at duty 0 (1 ms)
- STEP, 50, added clocks per duty LSB; MIN_PULSE + (2^DUTY_W−1)·STEP < PERIOD_CYCLES required
- DEBOUNCE_CYCLES, 500_000, stable cycles before a level change is accepted
- clock  in  1  system clock (50 MHz PLL output)
- reset  in  1  asynchronous, active-low reset
- addr  in  12  word address, processor `address_dmem[11:0]`
- wen  in  1  write strobe (`wren`)
- wdata  in  32  write data
- rdata  out  32  registered read data
- hit  out  1  registered: the address sampled on the previous edge is a hub register
- btn_in  in  NUM_BTN  raw asynchronous button pins
- led  out  16  LED register
- servo_pwm  out  NUM_SERVO  servo control pulses

## Operation
- Address map: 0x006 LED (RW, bits[15:0]); 0x007 BTN_STATE (RO, debounced levels in bits[NUM_BTN−1:0]); 0x008 BTN_EDGE (R, W1C); 0x00B+i SERVO_DUTY[i], i < NUM_SERVO (RW, bits[DUTY_W−1:0]). Other addresses: hit=0, rdata=0, no effect.
- Unused read bits are 0. Writes to RO registers and to unmapped addresses are ignored.
- Buttons: 2-flop synchronizer, then a per-button counter. The counter resets whenever the synchronized input equals the debounced level. When it reaches DEBOUNCE_CYCLES−1, the debounced level flips and the counter clears.
- BTN_EDGE[b] sets on the cycle the debounced level of b goes 0→1. It holds until a write to 0x008 with wdata[b]=1. A set and a clear in the same cycle leave the bit set.
- PWM: one free-running counter shared by all channels, 0..PERIOD_CYCLES−1, then wraps to 0. When counter==0, each channel loads its shadow register from SERVO_DUTY[i]. servo_pwm[i] = (counter < MIN_PULSE + shadow_i·STEP); compute in 32 bits.
- A duty write therefore takes effect only at the next period start. Every pulse is whole; there are no runt pulses.

## Timing
- A write commits on the rising edge where wen=1. The register readback shows the new value on the next read.
- Read: addr sampled at edge N; rdata and hit are valid after edge N, usable in cycle N+1 (same as RAM). A read and a write to the same register in one cycle return the old value.
- Button press to BTN_STATE: 2 (synchronizer) + DEBOUNCE_CYCLES clocks. BTN_EDGE sets on the same edge as BTN_STATE.
- Duty write to visible PWM change: at most PERIOD_CYCLES clocks.
- reset low (asynchronous) clears everything: led=0, rdata=0, hit=0, servo_pwm=0, all duty and shadow registers, PWM counter, synchronizers, debounce counters, debounced levels and edge flags.
- Reset released mid-period: the counter restarts from 0 and shadows load 0, so the first pulse is exactly MIN_PULSE wide. Reset has no synchronous component.

## Structure
- Package `mmio_pkg`: address constants ADDR_LED, ADDR_BTN_STATE, ADDR_BTN_EDGE, ADDR_SERVO_BASE; default timing constants.
- Sub-module `pwm_channel`, instantiated NUM_SERVO times. It contains the shadow register and compare, and takes the shared counter and a period-start strobe.
- Debounce logic stays inline in a generate loop. Decode and read mux stay in the top.

## Test plan
Simulation overrides: PERIOD_CYCLES=1000, MIN_PULSE=100, STEP=1, DEBOUNCE_CYCLES=4.
- Reset: hold reset low, then release → all outputs 0; first servo_pwm pulses are exactly 100 clocks high per 1000.
- Duty update: write 0x00B=200 mid-period → the current period keeps its old width; the next period pulse is 300 clocks; read 0x00B → rdata=200 one cycle after addr, hit=1.
- Debounce: btn_in[0] toggles with 3-cycle glitches, then holds high → BTN_STATE stays 0 during glitches; it becomes 1 exactly 2+4 clocks after the stable high; BTN_EDGE[0]=1.
- W1C: write 0x008=0x1 on the same edge a new rising edge sets bit 0 → bit stays 1; a later clear with no new edge → 0. Writing 0x2 leaves bit 0 unchanged.
- Multi-channel: write distinct duties to all NUM_SERVO channels → each pulse width = 100+duty. Write 0x006=0xA5A5 → led=0xA5A5.
- Unmapped: read 0x00F and write 0x010 → hit=0, rdata=0, no register changes.
